// File: rtl/pc_fetch_queue.sv
// pc_fetch_queue: N-wide fetch stage feeding dispatch from a circular instruction queue.
// Define PC_FETCH_BYPASS_EN to forward an incoming line straight to dispatch when the queue is empty.
module pc_fetch_queue #(
    parameter int          FETCH_WIDTH    = 2,
    parameter int          DISPATCH_WIDTH = 2,
    parameter int          IQ_DEPTH       = 8,
    parameter logic [63:0] RESET_PC       = 64'h0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pc_enable,
    input  logic                          branch_is_taken,
    input  logic [63:0]                   fu_target_pc,
    input  logic [32*FETCH_WIDTH-1:0]     Imem2proc_data,
    input  logic                          Imem2proc_valid,
    input  logic                          memory_structure_hazard_stall,
    input  logic                          rs_stall,
    input  logic                          rob_stall,
    input  logic                          rat_stall,
    output logic [63:0]                   proc2Imem_addr,
    output logic [63:0]                   fetch_pc_out,
    output logic [32*DISPATCH_WIDTH-1:0]  inst_out,
    output logic [64*DISPATCH_WIDTH-1:0]  inst_pc_out,
    output logic [DISPATCH_WIDTH-1:0]     inst_is_valid,
    output logic [$clog2(IQ_DEPTH+1)-1:0] iq_count
);
    localparam int LB = $clog2(4 * FETCH_WIDTH);
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam int BN = (FETCH_WIDTH < DISPATCH_WIDTH) ? FETCH_WIDTH : DISPATCH_WIDTH;
    localparam logic [31:0] FW32 = FETCH_WIDTH;
    localparam logic [31:0] DW32 = DISPATCH_WIDTH;
    localparam logic [31:0] QD32 = IQ_DEPTH;
    localparam logic [63:0] LINE_BYTES = 64'(4 * FETCH_WIDTH);

    logic [63:0]   pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   iq_inst [IQ_DEPTH];
    logic [63:0]   iq_pc   [IQ_DEPTH];

    logic [63:0] line_base;
    logic [31:0] cnt32;
    logic [31:0] off;
    logic [31:0] n_useful;
    logic [31:0] pop_cnt;
    logic [31:0] skip;
    logic [31:0] n_push;
    logic [31:0] disp_n;
    logic        dstall;
    logic        fetch_ok;
    logic        bypass;
    logic [31:0] cmp_inst  [FETCH_WIDTH];
    logic [63:0] cmp_pc    [FETCH_WIDTH];
    logic [31:0] push_inst [FETCH_WIDTH];
    logic [63:0] push_pc   [FETCH_WIDTH];
    logic        unused_ok;

    assign line_base      = {pc[63:LB], {LB{1'b0}}};
    assign proc2Imem_addr = line_base;
    assign fetch_pc_out   = pc;
    assign iq_count       = count;
    assign unused_ok      = ^fu_target_pc[1:0];

    always_comb begin
        cnt32    = 32'(count);
        dstall   = rs_stall | rob_stall | rat_stall;
        off      = 32'((pc >> 2) & 64'(FETCH_WIDTH - 1));
        n_useful = FW32 - off;
        pop_cnt  = '0;
        if (!dstall && !branch_is_taken)
            pop_cnt = (cnt32 < DW32) ? cnt32 : DW32;
        fetch_ok = reset & pc_enable & Imem2proc_valid
                 & !memory_structure_hazard_stall & !branch_is_taken
                 & (QD32 - cnt32 + pop_cnt >= FW32);
`ifdef PC_FETCH_BYPASS_EN
        bypass = (cnt32 == 0) && fetch_ok && !dstall;
`else
        bypass = 1'b0;
`endif
        skip   = '0;
        if (bypass)
            skip = (n_useful < DW32) ? n_useful : DW32;
        n_push = fetch_ok ? n_useful - skip : '0;
        disp_n = bypass ? skip : pop_cnt;
    end

    // Compact the useful slots (k >= offset) down to index 0, then drop the bypassed ones.
    always_comb begin
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            cmp_inst[j]  = '0;
            cmp_pc[j]    = '0;
            push_inst[j] = '0;
            push_pc[j]   = '0;
        end
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (32'(k) == 32'(j) + off) begin
                    cmp_inst[j] = Imem2proc_data[32*k +: 32];
                    cmp_pc[j]   = line_base + 64'(4 * k);
                end
            end
        end
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (32'(k) == 32'(j) + skip) begin
                    push_inst[j] = cmp_inst[k];
                    push_pc[j]   = cmp_pc[k];
                end
            end
        end
    end

    always_comb begin
        inst_out      = '0;
        inst_pc_out   = '0;
        inst_is_valid = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (!bypass && 32'(i) < disp_n) begin
                inst_is_valid[i]        = 1'b1;
                inst_out[32*i +: 32]    = iq_inst[head + PW'(i)];
                inst_pc_out[64*i +: 64] = iq_pc[head + PW'(i)];
            end
        end
        for (int i = 0; i < BN; i++) begin
            if (bypass && 32'(i) < disp_n) begin
                inst_is_valid[i]        = 1'b1;
                inst_out[32*i +: 32]    = cmp_inst[i];
                inst_pc_out[64*i +: 64] = cmp_pc[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (branch_is_taken) begin
            pc    <= {fu_target_pc[63:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_cnt);
            tail  <= tail + PW'(n_push);
            count <= CW'(cnt32 + n_push - pop_cnt);
            if (fetch_ok)
                pc <= line_base + LINE_BYTES;
        end
    end

    // Storage needs no reset: entries are only visible between head and tail.
    always_ff @(posedge clock) begin
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (32'(j) < n_push) begin
                iq_inst[tail + PW'(j)] <= push_inst[j];
                iq_pc[tail + PW'(j)]   <= push_pc[j];
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_queue.sv
// tb_pc_fetch_queue: scoreboard bench for pc_fetch_queue (2-wide fetch/dispatch, 8 entries).
// Expected instructions are queued when a line is accepted and popped as dispatch slots appear.
module tb_pc_fetch_queue;
    logic         clock = 1'b0;
    logic         reset;
    logic         pc_enable;
    logic         branch_is_taken;
    logic [63:0]  fu_target_pc;
    logic [63:0]  Imem2proc_data;
    logic         Imem2proc_valid;
    logic         memory_structure_hazard_stall;
    logic         rs_stall;
    logic         rob_stall;
    logic         rat_stall;
    logic [63:0]  proc2Imem_addr;
    logic [63:0]  fetch_pc_out;
    logic [63:0]  inst_out;
    logic [127:0] inst_pc_out;
    logic [1:0]   inst_is_valid;
    logic [3:0]   iq_count;

    pc_fetch_queue #(
        .FETCH_WIDTH(2), .DISPATCH_WIDTH(2), .IQ_DEPTH(8), .RESET_PC(64'h0)
    ) dut (
        .clock(clock), .reset(reset), .pc_enable(pc_enable),
        .branch_is_taken(branch_is_taken), .fu_target_pc(fu_target_pc),
        .Imem2proc_data(Imem2proc_data), .Imem2proc_valid(Imem2proc_valid),
        .memory_structure_hazard_stall(memory_structure_hazard_stall),
        .rs_stall(rs_stall), .rob_stall(rob_stall), .rat_stall(rat_stall),
        .proc2Imem_addr(proc2Imem_addr), .fetch_pc_out(fetch_pc_out),
        .inst_out(inst_out), .inst_pc_out(inst_pc_out),
        .inst_is_valid(inst_is_valid), .iq_count(iq_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] mpc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_line(input logic [63:0] base, input int off);
        ent_t e;
        for (int k = off; k < 2; k++) begin
            e.inst = Imem2proc_data[32*k +: 32];
            e.pc   = base + 64'(4 * k);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_idle();
        pc_enable = 1'b1;
        branch_is_taken = 1'b0;
        fu_target_pc = '0;
        Imem2proc_data = '0;
        Imem2proc_valid = 1'b0;
        memory_structure_hazard_stall = 1'b0;
        rs_stall = 1'b0;
        rob_stall = 1'b0;
        rat_stall = 1'b0;
    endtask

    // Check combinational outputs at the falling edge, then advance the model over the rising edge.
    task automatic cycle();
        int          size0;
        int          n;
        int          off;
        bit          ds;
        bit          acc;
        bit          byp;
        logic [63:0] base;
        ent_t        e;
        @(negedge clock);
        ds    = rs_stall | rob_stall | rat_stall;
        size0 = exp_q.size();
        base  = {mpc[63:3], 3'b000};
        off   = int'(mpc[2]);
        chk("iq_count", 64'(iq_count), 64'(size0));
        chk("fetch_pc", fetch_pc_out, mpc);
        chk("imem_addr", proc2Imem_addr, base);
        n   = (ds || branch_is_taken) ? 0 : ((size0 < 2) ? size0 : 2);
        acc = pc_enable && Imem2proc_valid && !memory_structure_hazard_stall
              && !branch_is_taken && (8 - size0 + n >= 2);
        byp = 1'b0;
`ifdef PC_FETCH_BYPASS_EN
        byp = (size0 == 0) && acc && !ds;
`endif
        if (byp) begin
            push_line(base, off);
            n = (exp_q.size() < 2) ? exp_q.size() : 2;
        end
        chk("valid", 64'(inst_is_valid), 64'((1 << n) - 1));
        for (int i = 0; i < 2; i++) begin
            if (i < n) begin
                e = exp_q.pop_front();
                chk("inst", 64'(inst_out[32*i +: 32]), 64'(e.inst));
                chk("inst_pc", inst_pc_out[64*i +: 64], e.pc);
            end else begin
                chk("inst_idle", 64'(inst_out[32*i +: 32]), 64'h0);
                chk("pc_idle", inst_pc_out[64*i +: 64], 64'h0);
            end
        end
        if (acc && !byp)
            push_line(base, off);
        if (acc)
            mpc = base + 64'd8;
        if (branch_is_taken) begin
            exp_q.delete();
            mpc = {fu_target_pc[63:2], 2'b00};
        end
        @(posedge clock);
        #1;
    endtask

    task automatic line(input logic [63:0] d);
        Imem2proc_valid = 1'b1;
        Imem2proc_data = d;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        mpc = 64'h0;
        #1;
        chk("rst_addr", proc2Imem_addr, 64'h0);
        chk("rst_pc", fetch_pc_out, 64'h0);
        chk("rst_valid", 64'(inst_is_valid), 64'h0);
        chk("rst_count", 64'(iq_count), 64'h0);
        chk("rst_inst", inst_out, 64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        line(64'h1234_4567_5678_3456);
        cycle();
        set_idle();
        cycle();
        for (int i = 0; i < 6; i++) begin
            line({$urandom, $urandom});
            cycle();
        end

        // redirect to an unaligned target while a line is returning
        line({$urandom, $urandom});
        branch_is_taken = 1'b1;
        fu_target_pc = 64'h105;
        cycle();
        set_idle();
        line(64'h0000_0010_9008_1406);
        cycle();
        set_idle();
        cycle();

        rs_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            line({$urandom, $urandom});
            cycle();
        end
        set_idle();
        for (int i = 0; i < 5; i++) cycle();

        for (int b = 0; b < 3; b++) begin
            set_idle();
            repeat (2) begin
                line({$urandom, $urandom});
                rob_stall = 1'b1;
                cycle();
            end
            rob_stall = 1'b0;
            line({$urandom, $urandom});
            if (b == 0) Imem2proc_valid = 1'b0;
            if (b == 1) pc_enable = 1'b0;
            if (b == 2) memory_structure_hazard_stall = 1'b1;
            cycle();
        end

        set_idle();
        repeat (3) begin
            line({$urandom, $urandom});
            rat_stall = 1'b1;
            cycle();
        end
        rat_stall = 1'b0;
        line({$urandom, $urandom});
        rob_stall = 1'b1;
        branch_is_taken = 1'b1;
        fu_target_pc = 64'h2000;
        cycle();
        set_idle();
        cycle();

        for (int i = 0; i < 200; i++) begin
            set_idle();
            if ($urandom_range(0, 3) != 0) line({$urandom, $urandom});
            rs_stall = ($urandom_range(0, 4) == 0);
            rob_stall = ($urandom_range(0, 7) == 0);
            rat_stall = ($urandom_range(0, 7) == 0);
            pc_enable = ($urandom_range(0, 9) != 0);
            memory_structure_hazard_stall = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                branch_is_taken = 1'b1;
                fu_target_pc = {$urandom, $urandom};
            end
            cycle();
        end

        // asynchronous reset in the middle of a cycle
        set_idle();
        repeat (3) begin
            line({$urandom, $urandom});
            rs_stall = 1'b1;
            cycle();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(inst_is_valid), 64'h0);
        chk("arst_count", 64'(iq_count), 64'h0);
        chk("arst_inst", inst_out, 64'h0);
        chk("arst_ipc", inst_pc_out[63:0], 64'h0);
        chk("arst_addr", proc2Imem_addr, 64'h0);
        chk("arst_pc", fetch_pc_out, 64'h0);
        exp_q.delete();
        mpc = 64'h0;
        set_idle();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        line(64'h5610_7687_6467_1425);
        cycle();
        set_idle();
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_queue.md
# pc_fetch_queue

Parametrised N-wide fetch stage for the out-of-order core. It holds the program counter, requests aligned instruction lines from instruction memory, and buffers the returned instructions in a circular instruction queue. Each cycle it presents up to DISPATCH_WIDTH instructions in program order to the RAT/RS/RoB dispatch stage. Taken branches resolved in the functional units redirect the PC and flush the queue.

## Interface
- FETCH_WIDTH, 2: instructions per memory line (power of two).
- DISPATCH_WIDTH, 2: maximum instructions presented per cycle; must be ≤ IQ_DEPTH.
- IQ_DEPTH, 8: instruction queue entries (power of two, ≥ FETCH_WIDTH).
- RESET_PC, 64'h0: PC loaded on reset.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_enable  in  1  global fetch enable.
- branch_is_taken  in  1  redirect request.
- fu_target_pc  in  64  redirect target; bits [1:0] are ignored.
- Imem2proc_data  in  32*FETCH_WIDTH  line data; slot k is bits [32k+31:32k].
- Imem2proc_valid  in  1  line data valid this cycle.
- memory_structure_hazard_stall  in  1  D-side owns memory; fetch is blocked.
- rs_stall, rob_stall, rat_stall  in  1 each  dispatch back-pressure.
- proc2Imem_addr  out  64  line-aligned fetch address.
- fetch_pc_out  out  64  current PC register.
- inst_out  out  32*DISPATCH_WIDTH  slot i is the (i+1)-th oldest queued instruction.
- inst_pc_out  out  64*DISPATCH_WIDTH  PC of each slot.
- inst_is_valid  out  DISPATCH_WIDTH  per-slot valid; always contiguous from slot 0.
- iq_count  out  $clog2(IQ_DEPTH+1)  occupied entries.

## Operation
- LB = log2(4*FETCH_WIDTH). proc2Imem_addr = {PC[63:LB], LB'b0}. Line slot k is useful iff k ≥ PC[LB-1:2].
- dstall = rs_stall | rob_stall | rat_stall.
- pop_cnt:
  - 0 when dstall or branch_is_taken.
  - Otherwise min(iq_count, DISPATCH_WIDTH).
- inst_is_valid[i] = (i < pop_cnt). Every valid slot is consumed at the next edge.
- fetch_ok = pc_enable & Imem2proc_valid & !memory_structure_hazard_stall & !branch_is_taken & (IQ_DEPTH − iq_count + pop_cnt ≥ FETCH_WIDTH).
- On fetch_ok:
  - The useful slots are pushed in ascending order, each tagged with PC line base + 4k.
  - PC ← line base + 4*FETCH_WIDTH, modulo 2^64.
- On !fetch_ok: PC is held and nothing is pushed.
- Priority, highest first: reset, then branch_is_taken, then dispatch/fetch.
- branch_is_taken at an edge:
  - Head, tail and count are cleared.
  - PC ← {fu_target_pc[63:2], 2'b00}.
  - The returning line is discarded.
- Queue storage:
  - Circular buffer with head/tail pointers that wrap modulo IQ_DEPTH.
  - iq_count_next = iq_count + pushed − pop_cnt; it never exceeds IQ_DEPTH.
- Invalid slots of inst_out and inst_pc_out drive 0.

## Timing
- Reset (reset = 0), applied immediately and asynchronously:
  - PC = RESET_PC.
  - Queue empty, iq_count = 0.
  - inst_is_valid = 0, inst_out = 0, inst_pc_out = 0.
  - proc2Imem_addr = aligned RESET_PC, fetch_pc_out = RESET_PC.
- Reset asserted mid-operation discards all queue contents.
- proc2Imem_addr, inst_* are combinational from registered state (plus stall and branch gating).
- Fetch-to-dispatch latency: a line accepted at edge t appears on outputs in cycle t+1 (without bypass).
- Redirect: the target address is on proc2Imem_addr in the cycle after branch_is_taken. The earliest target instruction is valid one cycle later.
- Full queue: fetch is refused unless that cycle's pops free enough room. Empty queue: inst_is_valid = 0.

## Configuration
- PC_FETCH_BYPASS_EN defined:
  - Applies when iq_count = 0, fetch_ok = 1 and dstall = 0.
  - The useful slots of the incoming line are compacted onto inst_out/inst_pc_out/inst_is_valid in the same cycle.
  - The first up to DISPATCH_WIDTH of them count as popped and are not written to the queue; only the remainder is pushed.
  - Fetch-to-dispatch latency becomes 0.
- PC_FETCH_BYPASS_EN undefined: outputs come only from the queue, with latency 1.

## Test plan
(FETCH_WIDTH = 2, DISPATCH_WIDTH = 2, IQ_DEPTH = 8, RESET_PC = 0, bypass off unless stated.)
- Reset and basic fetch:
  - Stimulus: reset = 0.
  - Required response: proc2Imem_addr = 0, inst_is_valid = 2'b00, iq_count = 0.
  - Stimulus: release reset, supply 64'h1234_4567_5678_3456 valid.
  - Required response next cycle: slot0 = 5678_3456 @ 0x0, slot1 = 1234_4567 @ 0x4, valid = 2'b11, fetch_pc_out = 8.
- Unaligned redirect:
  - Stimulus: branch_is_taken = 1, fu_target_pc = 0x104, with a valid line present.
  - Required response: line dropped, iq_count = 0, next proc2Imem_addr = 0x100.
  - Stimulus: returned line 64'h0000_0010_9008_1406.
  - Required response: only 0000_0010 @ 0x104 is queued; it dispatches with valid = 2'b01.
- Back-pressure:
  - Stimulus: rs_stall = 1 for 6 cycles, lines valid.
  - Required response: inst_is_valid = 0 throughout; iq_count goes 2, 4, 6, 8, then holds at 8 with PC frozen.
  - Stimulus: release the stall.
  - Required response: 2 instructions dispatched per cycle in PC order.
- Fetch blocks:
  - Stimulus: Imem2proc_valid = 0, or pc_enable = 0, or memory_structure_hazard_stall = 1, each for 1 cycle.
  - Required response: PC unchanged and nothing pushed, while queued instructions still dispatch.
- Priority and async reset:
  - Stimulus: branch_is_taken and rob_stall together, with a valid line.
  - Required response: the branch wins; the queue is flushed.
  - Stimulus: drive reset low mid-cycle.
  - Required response: outputs go to reset values before the next edge.
- Bypass (PC_FETCH_BYPASS_EN defined):
  - Stimulus: empty queue, line 64'h5610_7687_6467_1425 valid.
  - Required response: slot0 = 6467_1425 and slot1 = 5610_7687 are valid in the same cycle, and iq_count stays 0.
